// File: rtl/imem_port_arbiter.sv
// Purpose: shares one combinational-read imem between CPU fetch and a windowed scan engine.
// Latency: fetch data 1 cycle after grant; each scan beat 1 cycle after its slot; s_done 1 cycle after DONE.
// Backpressure: fetch has priority; a scan stalled STARVE_MAX cycles in a row steals exactly one cycle.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   f_req/f_addr    fetch request (level) and word address; f_gnt is the same-cycle grant
//   f_valid/f_q     registered fetch data for the previous cycle's granted fetch
//   s_start/s_base/s_len   scan launch (accepted only in IDLE), first address, word count 0..2^ADDR_W
//   s_busy/s_valid/s_addr/s_q/s_done   scan status and registered beat stream
//   imem_addr/imem_q       address to, and combinational data from, the shared imem
//   s_sum           (only with SCAN_CHECKSUM_EN defined) rotate-xor checksum of the scanned words
module imem_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_q,
    input  logic              s_start,
    input  logic [ADDR_W-1:0] s_base,
    input  logic [ADDR_W:0]   s_len,
    output logic              s_busy,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_q,
    output logic              s_done,
`ifdef SCAN_CHECKSUM_EN
    output logic [DATA_W-1:0] s_sum,
`endif
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_q
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     rem;
    logic [STARVE_W-1:0] starve;
    logic                scan_slot;
    logic                start_ok;

    // The scan gets the port when fetch is idle, or when it has waited long enough.
    assign scan_slot = (state == ST_SCAN) &&
                       (!f_req || (starve == STARVE_W'(STARVE_MAX)));
    assign f_gnt     = f_req && !scan_slot;
    assign imem_addr = scan_slot ? ptr : f_addr;
    // Starts are only honoured from IDLE; SCAN and DONE both drop them.
    assign start_ok  = (state == ST_IDLE) && s_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            rem     <= '0;
            starve  <= '0;
            f_valid <= 1'b0;
            f_q     <= '0;
            s_busy  <= 1'b0;
            s_valid <= 1'b0;
            s_addr  <= '0;
            s_q     <= '0;
            s_done  <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
            s_sum   <= '0;
`endif
        end else begin
            f_valid <= f_gnt;
            if (f_gnt) begin
                f_q <= imem_q;
            end

            s_valid <= scan_slot;
            if (scan_slot) begin
                s_addr <= ptr;
                s_q    <= imem_q;
                ptr    <= ptr + ADDR_W'(1);
                rem    <= rem - (ADDR_W+1)'(1);
            end

            // Outside SCAN scan_slot is 0 and the counter is forced to zero.
            if ((state == ST_SCAN) && !scan_slot && f_req) begin
                starve <= starve + STARVE_W'(1);
            end else begin
                starve <= '0;
            end

            // DONE lasts one cycle; the pulse lands in the cycle after it.
            s_done <= (state == ST_DONE);

`ifdef SCAN_CHECKSUM_EN
            if (start_ok) begin
                s_sum <= '0;
            end else if (scan_slot) begin
                s_sum <= {s_sum[DATA_W-2:0], s_sum[DATA_W-1]} ^ imem_q;
            end
`endif

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        if (s_len != '0) begin
                            state  <= ST_SCAN;
                            ptr    <= s_base;
                            rem    <= s_len;
                            s_busy <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_SCAN: begin
                    if (scan_slot && (rem == (ADDR_W+1)'(1))) begin
                        state  <= ST_DONE;
                        s_busy <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    s_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Purpose: randomized and directed bench for imem_port_arbiter against a queue-based reference model.
// Latency: one cycle per cyc() call; outputs sampled 1 time unit after the rising edge.
// Backpressure: model predicts every grant and beat; all checks go through chk().
module tb_imem_port_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [5:0]  f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_q;
    logic        s_start;
    logic [5:0]  s_base;
    logic [6:0]  s_len;
    logic        s_busy;
    logic        s_valid;
    logic [5:0]  s_addr;
    logic [31:0] s_q;
    logic        s_done;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
`ifdef SCAN_CHECKSUM_EN
    logic [31:0] s_sum;
`endif

    logic [31:0] mem [64];
    assign imem_q = mem[imem_addr];

    imem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_valid   (f_valid),
        .f_q       (f_q),
        .s_start   (s_start),
        .s_base    (s_base),
        .s_len     (s_len),
        .s_busy    (s_busy),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_q       (s_q),
        .s_done    (s_done),
`ifdef SCAN_CHECKSUM_EN
        .s_sum     (s_sum),
`endif
        .imem_addr (imem_addr),
        .imem_q    (imem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending scan addresses, DONE flag, stall count, expected registers.
    int          q[$];
    bit          m_done;
    int          m_stall;
    logic        e_fv, e_sv, e_sd, e_busy;
    logic [31:0] e_fq, e_sq, e_sum;
    logic [5:0]  e_sa;

    // Observation bookkeeping for the directed checks.
    int cyc_n;
    int beat_cnt;
    int last_beat_cyc;
    int done_cyc;
    int beat_cycs[$];
    int beat_addrs[$];
    logic [31:0] beat_data[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done  = 1'b0;
        m_stall = 0;
        e_fv = 0; e_sv = 0; e_sd = 0; e_busy = 0;
        e_fq = 0; e_sq = 0; e_sum = 0; e_sa = 0;
    endtask

    task automatic check_regs();
        chk("f_valid", f_valid, e_fv);
        chk("f_q",     f_q,     e_fq);
        chk("s_valid", s_valid, e_sv);
        chk("s_addr",  s_addr,  e_sa);
        chk("s_q",     s_q,     e_sq);
        chk("s_done",  s_done,  e_sd);
        chk("s_busy",  s_busy,  e_busy);
`ifdef SCAN_CHECKSUM_EN
        chk("s_sum",   s_sum,   e_sum);
`endif
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registers.
    task automatic cyc(input logic req, input logic [5:0] fa, input logic st,
                       input logic [5:0] sb, input logic [6:0] sl);
        logic slot, gnt, new_done;
        logic [5:0] exp_addr;
        int a;
        f_req = req; f_addr = fa; s_start = st; s_base = sb; s_len = sl;
        #2;
        slot = (q.size() > 0) && (!req || m_stall == SM);
        gnt  = req && !slot;
        exp_addr = fa;
        if (slot) exp_addr = 6'(q[0]);
        chk("f_gnt", f_gnt, gnt);
        chk("imem_addr", imem_addr, exp_addr);
        @(posedge clk);
        e_fv = gnt;
        if (gnt) e_fq = mem[fa];
        e_sv = slot;
        e_sd = m_done;
        if (q.size() > 0) m_stall = slot ? 0 : m_stall + 1;
        else m_stall = 0;
        new_done = 1'b0;
        if (slot) begin
            a = q.pop_front();
            e_sa  = 6'(a);
            e_sq  = mem[a];
            e_sum = {e_sum[30:0], e_sum[31]} ^ mem[a];
            if (q.size() == 0) new_done = 1'b1;
        end else if (q.size() == 0 && !m_done && st) begin
            e_sum = 0;
            if (sl == 0) new_done = 1'b1;
            else for (int i = 0; i < int'(sl); i++) q.push_back((int'(sb) + i) % 64);
        end
        m_done = new_done;
        e_busy = (q.size() > 0);
        cyc_n++;
        #1;
        check_regs();
        if (s_valid) begin
            beat_cnt++;
            last_beat_cyc = cyc_n;
            beat_cycs.push_back(cyc_n);
            beat_addrs.push_back(int'(s_addr));
            beat_data.push_back(s_q);
        end
        if (s_done) done_cyc = cyc_n;
        s_start = 1'b0;
    endtask

    task automatic clear_obs();
        beat_cnt = 0; last_beat_cyc = -1; done_cyc = -1;
        beat_cycs.delete(); beat_addrs.delete(); beat_data.delete();
    endtask

    // Idle (or fetch-only) cycles until s_done, bounded.
    task automatic run_until_done(input logic req, input int limit);
        int n;
        n = 0;
        while (done_cyc < 0 && n < limit) begin
            cyc(req, 6'($urandom_range(0, 63)), 1'b0, 6'd0, 7'd0);
            n++;
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
    endtask

    // Asynchronous reset asserted mid-cycle; registered outputs must clear immediately.
    task automatic mid_reset();
        #2;
        f_req = 1'b0; s_start = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_f_valid", f_valid, 0);
        chk("rst_f_q",     f_q,     0);
        chk("rst_s_busy",  s_busy,  0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_s_addr",  s_addr,  0);
        chk("rst_s_q",     s_q,     0);
        chk("rst_s_done",  s_done,  0);
        chk("rst_f_gnt",   f_gnt,   0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [31:0] sum1;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (i < 47) ? $urandom : 32'h0;
        mem[0]  = 32'hf8000001;
        mem[1]  = 32'hf8008002;
        mem[3]  = 32'h8b050083;
        mem[46] = 32'hb400001f;
        reset = 1'b0; f_req = 0; f_addr = 0; s_start = 0; s_base = 0; s_len = 0;
        cyc_n = 0;
        clear_obs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: some activity, then async reset mid-run; stays idle afterwards.
        for (int i = 0; i < 6; i++) cyc(1'($urandom), 6'($urandom), i == 1, 6'd5, 7'd10);
        mid_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd0, 1'b0, 6'd0, 7'd0);
        chk("idle_after_reset_busy", s_busy, 0);

        // 2: fetch.
        cyc(1'b1, 6'd3, 1'b0, 6'd0, 7'd0);
        chk("fetch3_valid", f_valid, 1);
        chk("fetch3_q", f_q, 32'h8b050083);
        cyc(1'b1, 6'd46, 1'b0, 6'd0, 7'd0);
        chk("fetch46_q", f_q, 32'hb400001f);
        cyc(1'b0, 6'd46, 1'b0, 6'd0, 7'd0);
        chk("fetch_idle_valid", f_valid, 0);

        // 3: whole-program scan, twice.
        clear_obs();
        cyc(1'b0, 6'd0, 1'b1, 6'd0, 7'd47);
        run_until_done(1'b0, 80);
        chk("scan47_beats", beat_cnt, 47);
        chk("scan47_done_after_last", done_cyc - last_beat_cyc, 1);
        chk("scan47_last_addr", beat_addrs[beat_addrs.size()-1], 46);
`ifdef SCAN_CHECKSUM_EN
        sum1 = s_sum;
        clear_obs();
        cyc(1'b0, 6'd0, 1'b1, 6'd0, 7'd47);
        run_until_done(1'b0, 80);
        chk("scan47_sum_repeat", s_sum, sum1);
`endif

        // 4: wrap-around window.
        clear_obs();
        cyc(1'b0, 6'd0, 1'b1, 6'd62, 7'd4);
        run_until_done(1'b0, 20);
        chk("wrap_beats", beat_cnt, 4);
        if (beat_cnt == 4) begin
            chk("wrap_addr0", beat_addrs[0], 62);
            chk("wrap_addr2", beat_addrs[2], 0);
            chk("wrap_q2", beat_data[2], 32'hf8000001);
            chk("wrap_q3", beat_data[3], 32'hf8008002);
        end

        // 5: contention - fetch held, scan beat every STARVE_MAX+1 cycles.
        clear_obs();
        cyc(1'b1, 6'd7, 1'b1, 6'd20, 7'd5);
        run_until_done(1'b1, 60);
        chk("contend_beats", beat_cnt, 5);
        for (int i = 1; i < beat_cycs.size(); i++)
            chk("contend_interval", beat_cycs[i] - beat_cycs[i-1], SM + 1);

        // 6a: empty scan.
        clear_obs();
        cyc(1'b0, 6'd0, 1'b1, 6'd9, 7'd0);
        chk("len0_done_early", s_done, 0);
        cyc(1'b0, 6'd0, 1'b0, 6'd0, 7'd0);
        chk("len0_done", s_done, 1);
        chk("len0_no_beats", beat_cnt, 0);

        // 6b: start during a scan is ignored.
        clear_obs();
        cyc(1'b0, 6'd0, 1'b1, 6'd10, 7'd6);
        cyc(1'b0, 6'd0, 1'b0, 6'd0, 7'd0);
        cyc(1'b0, 6'd0, 1'b1, 6'd40, 7'd3);
        run_until_done(1'b0, 20);
        chk("ignore_start_beats", beat_cnt, 6);
        chk("ignore_start_last", beat_addrs[beat_addrs.size()-1], 15);

        // 6c: reset during a scan.
        clear_obs();
        cyc(1'b0, 6'd0, 1'b1, 6'd30, 7'd20);
        cyc(1'b1, 6'd2, 1'b0, 6'd0, 7'd0);
        cyc(1'b0, 6'd2, 1'b0, 6'd0, 7'd0);
        mid_reset();
        for (int i = 0; i < 25; i++) cyc(1'b0, 6'd0, 1'b0, 6'd0, 7'd0);
        chk("rst_scan_no_done", done_cyc, -1);
        chk("rst_scan_busy", s_busy, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 99) < 60), 6'($urandom), ($urandom_range(0, 99) < 8),
                6'($urandom), 7'($urandom_range(0, 64)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
